// File: rtl/serial_mod_n_if.sv
// Serial mod-N bit stream bus: bit/frame strobes in, registered remainder and frame results out.
// No backpressure: the producer owns in_valid, the block accepts every qualified bit.
interface serial_mod_n_if #(
    parameter int DIVISOR = 3,
    parameter int CNT_W   = 8
);
    localparam int RW = $clog2(DIVISOR);

    logic             clr;
    logic             in_valid;
    logic             in;
    logic             in_last;
    logic [RW-1:0]    rem;
    logic             div;
    logic [CNT_W-1:0] bit_cnt;
    logic             frame_valid;
    logic [RW-1:0]    frame_rem;
    logic             frame_div;

    modport master (
        output clr, in_valid, in, in_last,
        input  rem, div, bit_cnt, frame_valid, frame_rem, frame_div
    );

    modport slave (
        input  clr, in_valid, in, in_last,
        output rem, div, bit_cnt, frame_valid, frame_rem, frame_div
    );
endinterface

// File: rtl/serial_mod_n.sv
// Running remainder of a serial word mod DIVISOR, one bit per accepted cycle, latency 1.
// No backpressure: every in_valid bit is absorbed; clr aborts the frame and wins over in_valid.
module serial_mod_n #(
    parameter int DIVISOR   = 3,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input logic           clk,
    input logic           rst,
    serial_mod_n_if.slave bus
);
    localparam int RW = $clog2(DIVISOR);
    localparam logic [RW:0]      N_EXT   = DIVISOR[RW:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       sync_q;
    logic [RW-1:0]    rem_q, rem_d;
    logic [RW-1:0]    w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             fv_q;
    logic [RW-1:0]    frem_q;
    logic             fdiv_q;

    logic [RW-1:0]    base_rem, base_w;
    logic [CNT_W-1:0] base_cnt;
    logic [RW:0]      sum, w2;
    logic             accept;

    // Reset release is re-timed so the first accepted bit lands well clear of the deassertion edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign accept = sync_q[1] & bus.in_valid;

    // A bit following a completed frame is computed from the initial state, not the held result.
    always_comb begin
        base_rem = start_q ? '0 : rem_q;
        base_w   = start_q ? RW'(1) : w_q;
        base_cnt = start_q ? '0 : cnt_q;
        sum      = '0;
        if (MSB_FIRST) begin
            sum = {base_rem, bus.in};
        end else begin
            sum = {1'b0, base_rem} + ({1'b0, base_w} & {(RW+1){bus.in}});
        end
        rem_d = (sum >= N_EXT) ? RW'(sum - N_EXT) : sum[RW-1:0];
        w2    = {base_w, 1'b0};
        w_d   = (w2 >= N_EXT) ? RW'(w2 - N_EXT) : w2[RW-1:0];
        cnt_d = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q   <= '0;
            w_q     <= RW'(1);
            cnt_q   <= '0;
            start_q <= 1'b0;
            fv_q    <= 1'b0;
            frem_q  <= '0;
            fdiv_q  <= 1'b0;
        end else begin
            fv_q <= 1'b0;
            if (bus.clr) begin
                rem_q   <= '0;
                w_q     <= RW'(1);
                cnt_q   <= '0;
                start_q <= 1'b0;
            end else if (accept) begin
                rem_q   <= rem_d;
                w_q     <= w_d;
                cnt_q   <= cnt_d;
                start_q <= bus.in_last;
                if (bus.in_last) begin
                    fv_q   <= 1'b1;
                    frem_q <= rem_d;
                    fdiv_q <= (rem_d == '0);
                end
            end
        end
    end

    assign bus.rem         = rem_q;
    assign bus.div         = (rem_q == '0);
    assign bus.bit_cnt     = cnt_q;
    assign bus.frame_valid = fv_q;
    assign bus.frame_rem   = frem_q;
    assign bus.frame_div   = fdiv_q;
endmodule

// File: tb/tb_serial_mod_n.sv
// Three instances (N=3 MSB/CNT_W=2, N=5 MSB, N=5 LSB) driven by directed vectors;
// expected records are queued at issue time and popped by per-instance monitors.
module tb_serial_mod_n;
    typedef struct packed {
        logic [7:0] rem;
        logic       div;
        logic [7:0] cnt;
        logic       fv;
        logic [7:0] frem;
        logic       fdiv;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_s = 1'b0, vld_s = 1'b0, bit_s = 1'b0, last_s = 1'b0;
    int   sel = 0;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    rec_t qa[$], qb[$], qc[$];
    rec_t last_rec[3];
    rec_t rst_rec;
    logic ev_a = 1'b0, ev_b = 1'b0, ev_c = 1'b0;

    always #5 clk = ~clk;

    serial_mod_n_if #(.DIVISOR(3), .CNT_W(2)) ifa ();
    serial_mod_n_if #(.DIVISOR(5), .CNT_W(8)) ifb ();
    serial_mod_n_if #(.DIVISOR(5), .CNT_W(8)) ifc ();

    serial_mod_n #(.DIVISOR(3), .MSB_FIRST(1'b1), .CNT_W(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    serial_mod_n #(.DIVISOR(5), .MSB_FIRST(1'b1), .CNT_W(8)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    serial_mod_n #(.DIVISOR(5), .MSB_FIRST(1'b0), .CNT_W(8)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    assign ifa.clr = clr_s & (sel == 0);
    assign ifa.in_valid = vld_s & (sel == 0);
    assign ifa.in = bit_s;
    assign ifa.in_last = last_s;
    assign ifb.clr = clr_s & (sel == 1);
    assign ifb.in_valid = vld_s & (sel == 1);
    assign ifb.in = bit_s;
    assign ifb.in_last = last_s;
    assign ifc.clr = clr_s & (sel == 2);
    assign ifc.in_valid = vld_s & (sel == 2);
    assign ifc.in = bit_s;
    assign ifc.in_last = last_s;

    // An output event is owed on the negedge after any edge that saw a bit or a clr.
    always @(posedge clk) begin
        ev_a <= rst & (ifa.in_valid | ifa.clr);
        ev_b <= rst & (ifb.in_valid | ifb.clr);
        ev_c <= rst & (ifc.in_valid | ifc.clr);
    end

    task automatic cmp(input int s, input string tag, input rec_t a, input rec_t e);
        chk_cnt++;
        if (a === e) begin
            pass_cnt++;
        end else begin
            $display("FAIL dut%0d %s @%0t: got rem=%0d div=%0d cnt=%0d fv=%0d frem=%0d fdiv=%0d, expected rem=%0d div=%0d cnt=%0d fv=%0d frem=%0d fdiv=%0d",
                     s, tag, $time, a.rem, a.div, a.cnt, a.fv, a.frem, a.fdiv,
                     e.rem, e.div, e.cnt, e.fv, e.frem, e.fdiv);
        end
    endtask

    task automatic mon(input int s, input rec_t act, input logic ev);
        rec_t e;
        int   n;
        if (!rst) begin
            case (s)
                0: qa.delete();
                1: qb.delete();
                default: qc.delete();
            endcase
            last_rec[s] = rst_rec;
            cmp(s, "reset", act, rst_rec);
        end else if (ev) begin
            case (s)
                0: n = qa.size();
                1: n = qb.size();
                default: n = qc.size();
            endcase
            if (n == 0) begin
                chk_cnt++;
                $display("FAIL dut%0d unexpected_output @%0t: got rem=%0d cnt=%0d, expected no event",
                         s, $time, act.rem, act.cnt);
            end else begin
                case (s)
                    0: e = qa.pop_front();
                    1: e = qb.pop_front();
                    default: e = qc.pop_front();
                endcase
                cmp(s, "step", act, e);
                last_rec[s] = e;
            end
        end else begin
            e = last_rec[s];
            e.fv = 1'b0;
            cmp(s, "hold", act, e);
            last_rec[s] = e;
        end
    endtask

    always @(negedge clk) begin
        rec_t a;
        a.rem = 8'(ifa.rem); a.div = ifa.div; a.cnt = 8'(ifa.bit_cnt);
        a.fv = ifa.frame_valid; a.frem = 8'(ifa.frame_rem); a.fdiv = ifa.frame_div;
        mon(0, a, ev_a);
    end

    always @(negedge clk) begin
        rec_t a;
        a.rem = 8'(ifb.rem); a.div = ifb.div; a.cnt = 8'(ifb.bit_cnt);
        a.fv = ifb.frame_valid; a.frem = 8'(ifb.frame_rem); a.fdiv = ifb.frame_div;
        mon(1, a, ev_b);
    end

    always @(negedge clk) begin
        rec_t a;
        a.rem = 8'(ifc.rem); a.div = ifc.div; a.cnt = 8'(ifc.bit_cnt);
        a.fv = ifc.frame_valid; a.frem = 8'(ifc.frame_rem); a.fdiv = ifc.frame_div;
        mon(2, a, ev_c);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input int s, input logic c, input logic v, input logic b, input logic l,
                       input int er, input int ec, input int efv, input int efrem, input int efdiv);
        rec_t e;
        e.rem  = 8'(er);
        e.div  = (er == 0);
        e.cnt  = 8'(ec);
        e.fv   = efv[0];
        e.frem = 8'(efrem);
        e.fdiv = efdiv[0];
        if (c || v) begin
            case (s)
                0: qa.push_back(e);
                1: qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
        sel = s; clr_s = c; vld_s = v; bit_s = b; last_s = l;
        @(posedge clk);
        #1;
        clr_s = 1'b0; vld_s = 1'b0; bit_s = 1'b0; last_s = 1'b0;
    endtask

    initial begin
        rst_rec = '0;
        rst_rec.div = 1'b1;
        for (int i = 0; i < 3; i++) last_rec[i] = rst_rec;

        #1;
        idle(3);
        rst = 1'b1;
        idle(3);

        // N=3 MSB first: 1,1,0 -> rem 1,0,0, frame_rem 0
        drv(0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
        drv(0, 0, 1, 1, 0, 0, 2, 0, 0, 0);
        drv(0, 0, 1, 0, 1, 0, 3, 1, 0, 1);
        idle(1);
        // back-to-back frames, then saturation of the 2-bit counter
        drv(0, 0, 1, 1, 0, 1, 1, 0, 0, 1);
        drv(0, 0, 1, 1, 1, 0, 2, 1, 0, 1);
        drv(0, 0, 1, 1, 0, 1, 1, 0, 0, 1);
        drv(0, 0, 1, 0, 0, 2, 2, 0, 0, 1);
        drv(0, 0, 1, 1, 0, 2, 3, 0, 0, 1);
        drv(0, 0, 1, 1, 0, 2, 3, 0, 0, 1);
        drv(0, 0, 1, 0, 0, 1, 3, 0, 0, 1);
        // clr beats in_valid+in_last: no frame, frame results untouched
        drv(0, 1, 1, 1, 1, 0, 0, 0, 0, 1);
        idle(1);
        drv(0, 0, 1, 1, 0, 1, 1, 0, 0, 1);
        drv(0, 0, 1, 0, 1, 2, 2, 1, 2, 0);
        // single-bit frame
        drv(0, 0, 1, 1, 1, 1, 1, 1, 1, 0);
        idle(1);

        // N=5 MSB first: 1,0,1,1 with gaps -> rem 1,2,0,1
        drv(1, 0, 1, 1, 0, 1, 1, 0, 0, 0);
        idle(2);
        drv(1, 0, 1, 0, 0, 2, 2, 0, 0, 0);
        idle(2);
        drv(1, 0, 1, 1, 0, 0, 3, 0, 0, 0);
        idle(2);
        drv(1, 0, 1, 1, 1, 1, 4, 1, 1, 0);
        idle(1);

        // N=5 LSB first: 1,1,0,1 -> weights 1,2,4,3, rem 1,3,3,1
        drv(2, 0, 1, 1, 0, 1, 1, 0, 0, 0);
        drv(2, 0, 1, 1, 0, 3, 2, 0, 0, 0);
        drv(2, 0, 1, 0, 0, 3, 3, 0, 0, 0);
        drv(2, 0, 1, 1, 1, 1, 4, 1, 1, 0);
        idle(1);

        // reset mid-frame discards the partial frame
        drv(0, 0, 1, 1, 0, 1, 1, 0, 1, 0);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(3);
        drv(0, 0, 1, 1, 1, 1, 1, 1, 1, 0);
        idle(2);

        chk_cnt++;
        if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL drain: got %0d/%0d/%0d pending, expected 0/0/0", qa.size(), qb.size(), qc.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/serial_mod_n.md
SERIAL_MOD_N -- requirements
Module: serial_mod_n

Interface
REQ-001 Parameter DIVISOR, default 3: modulus N, legal range 2..255.
REQ-002 Parameter MSB_FIRST, default 1: 1 = serial word arrives MSB first; 0 = LSB first.
REQ-003 Parameter CNT_W, default 8: width of bit_cnt.
REQ-004 Derived RW = $clog2(DIVISOR): width of all remainder ports.
REQ-005 clk  input  1  sole clock, rising-edge active.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 clr  input  1  synchronous frame abort; returns datapath to initial state.
REQ-008 in_valid  input  1  the in bit is accepted on this rising edge.
REQ-009 in  input  1  serial data bit.
REQ-010 in_last  input  1  the accepted bit is the final bit of the frame; qualified by in_valid.
REQ-011 rem  output  RW  running remainder of the bits accepted so far in the frame.
REQ-012 div  output  1  high when rem == 0.
REQ-013 bit_cnt  output  CNT_W  bits accepted in the current frame, saturating.
REQ-014 frame_valid  output  1  single-cycle pulse marking a completed frame.
REQ-015 frame_rem  output  RW  final remainder of the last completed frame.
REQ-016 frame_div  output  1  high when frame_rem == 0.

Function
REQ-017 All outputs are registered or decoded directly from registers; there is no combinational path from any input to any output.
REQ-018 With MSB_FIRST=1, each accepted bit updates rem to (2*rem + in) mod N.
REQ-019 With MSB_FIRST=0, an internal weight register w (reset value 1) applies; each accepted bit updates rem to (rem + in*w) mod N and w to (2*w) mod N.
REQ-020 The mod-N reduction uses the fact that both operands are below N: at most one conditional subtraction of N per step, computed at RW+1 bits. No divider is permitted.
REQ-021 An update is visible on rem, div and bit_cnt in the cycle after the accepting edge (latency 1).
REQ-022 When in_valid=0, rem, w, bit_cnt and the frame outputs hold their values; in and in_last are ignored.
REQ-023 bit_cnt increments by 1 per accepted bit and saturates at 2^CNT_W-1; it never wraps.
REQ-024 An accepted bit with in_last=1 performs the normal update, latches the resulting remainder into frame_rem and frame_div, and pulses frame_valid for exactly one cycle.
REQ-025 After a frame completes, rem, div and bit_cnt hold the final frame values until the next accepted bit.
REQ-026 The first accepted bit after a completed frame starts a new frame: it is computed from rem=0, w=1, bit_cnt=0 (a pending-start flag is required).
REQ-027 A frame may start on the cycle immediately after in_last (back-to-back frames); no idle cycle is required.
REQ-028 clr=1 sets rem=0, w=1, bit_cnt=0 and clears the pending-start flag. frame_rem and frame_div are unaffected.
REQ-029 clr has priority over in_valid in the same cycle: the bit is dropped and no frame_valid is produced, even when in_last=1.
REQ-030 A single-bit frame (in_valid and in_last on the first bit) is legal and produces frame_valid.

Reset
REQ-031 When rst is low, the block immediately, without waiting for clk, sets rem=0, div=1, w=1, bit_cnt=0, frame_valid=0, frame_rem=0, frame_div=0, and clears the pending-start flag.
REQ-032 Asserting rst mid-frame discards the partial frame.
REQ-033 Reset release is synchronised: the first bit is accepted no earlier than the second rising clk edge after rst rises.

Verification
REQ-034 N=3, MSB first, bits 1,1,0 with in_last on the third bit -> rem 1,0,0; div 0,1,1; frame_valid pulses once; frame_rem=0; frame_div=1.
REQ-035 N=5, MSB first, bits 1,0,1,1 (value 11) with in_valid gaps of 2 cycles -> rem 1,2,0,1 and held across the gaps; bit_cnt 1..4; frame_rem=1; frame_div=0.
REQ-036 N=5, LSB first, bits 1,1,0,1 (value 11) -> w 1,2,4,3; rem 1,3,3,1; frame_rem=1.
REQ-037 Back-to-back frames, N=3: frame 1,1 with in_last, then bit 1 on the next cycle -> frame_rem=0; new rem=1; bit_cnt=1.
REQ-038 CNT_W=2, 5 accepted bits -> bit_cnt 1,2,3,3,3.
REQ-039 Abort cases -> (a) clr together with in_valid and in_last mid-frame: rem=0, bit_cnt=0, no frame_valid; (b) rst low mid-frame: all outputs at reset values before the next clk edge.
